// File: rtl/vm_pkg.sv
// Shared types and helpers for the parametrised vending controller.
// Holds the FSM state enum, coin unit values, change-coin encodings and greedy coin selection.
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    PAYOUT = 2'd2
  } vm_state_e;

  // Coin values in nickel units
  localparam logic [2:0] NICKEL_U  = 3'd1;
  localparam logic [2:0] DIME_U    = 3'd2;
  localparam logic [2:0] QUARTER_U = 3'd5;

  localparam logic [1:0] CHG_NONE    = 2'b00;
  localparam logic [1:0] CHG_NICKEL  = 2'b01;
  localparam logic [1:0] CHG_DIME    = 2'b10;
  localparam logic [1:0] CHG_QUARTER = 2'b11;

  // Largest coin value that still fits in the amount owed (0 when nothing is owed)
  function automatic logic [2:0] greedy_unit(input logic [15:0] v);
    if (v >= 16'(QUARTER_U))   return QUARTER_U;
    else if (v >= 16'(DIME_U)) return DIME_U;
    else if (v != 16'd0)       return NICKEL_U;
    else                       return 3'd0;
  endfunction

  function automatic logic [1:0] coin_code(input logic [2:0] u);
    case (u)
      QUARTER_U: return CHG_QUARTER;
      DIME_U:    return CHG_DIME;
      NICKEL_U:  return CHG_NICKEL;
      default:   return CHG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/vm_change_dispenser.sv
// Serial greedy change payout: loads an amount, then ejects one coin per cycle
// (largest that fits) and flags the coin that clears the amount with chg_done.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rs,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [1:0]   chg_coin,
  output logic         chg_done
);

  logic [W-1:0] rem;
  logic [W-1:0] src;
  logic [2:0]   unit;

  // A load emits its first coin on the same edge, so change appears one cycle after the load
  always_comb begin
    src  = load ? load_val : rem;
    unit = greedy_unit(16'(src));
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      rem      <= '0;
      chg_coin <= CHG_NONE;
      chg_done <= 1'b0;
    end else begin
      rem      <= src - W'(unit);
      chg_coin <= coin_code(unit);
      chg_done <= (unit != 3'd0) && (src == W'(unit));
    end
  end

endmodule

// File: rtl/vending_machine_param.sv
// Multi-product vending controller: coin credit, priced selection with deny, cancel refund
// and greedy serial change. Optional per-product stock tracking under `VM_STOCK_EN`.
module vending_machine_param
  import vm_pkg::*;
#(
  parameter int                         N_PROD     = 4,
  parameter int                         PRICE_W    = 8,
  parameter logic [N_PROD*PRICE_W-1:0]  PRICE_LIST = {8'd7, 8'd5, 8'd4, 8'd3},
  parameter int                         MAX_CREDIT = 20,
  parameter int                         STOCK_INIT = 8,
  localparam int                        SEL_W      = (N_PROD > 1) ? $clog2(N_PROD) : 1,
  localparam int                        CREDIT_W   = $clog2(MAX_CREDIT + 1)
) (
  input  logic                clk,
  input  logic                rs,
  input  logic                nickle,
  input  logic                dime,
  input  logic                quarter,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_id,
  input  logic                cancel,
`ifdef VM_STOCK_EN
  input  logic                restock,
`endif
  output logic                s,
  output logic                sel_deny,
  output logic                coin_rej,
  output logic [1:0]          chg_coin,
  output logic                chg_done,
  output logic [CREDIT_W-1:0] credit,
`ifdef VM_STOCK_EN
  output logic [N_PROD-1:0]   sold_out,
`endif
  output logic                busy
);

  localparam int ACC_W = CREDIT_W + 4;

  vm_state_e state, state_nx;

  logic nickle_q, dime_q, quarter_q;
  logic nickle_e, dime_e, quarter_e, coin_any;
  logic [ACC_W-1:0]    coin_sum, add_total;
  logic [PRICE_W-1:0]  price_sel;
  logic                sel_hit, stocked, afford, vend_ok, cancel_go, vend_fire;
  logic [CREDIT_W-1:0] credit_nx, credit_after, credit_paid;
  logic                s_nx, deny_nx, rej_nx, disp_load;

  always_comb begin
    nickle_e  = nickle & ~nickle_q;
    dime_e    = dime & ~dime_q;
    quarter_e = quarter & ~quarter_q;
    coin_any  = nickle_e | dime_e | quarter_e;
    coin_sum  = ACC_W'(nickle_e ? NICKEL_U : 3'd0) + ACC_W'(dime_e ? DIME_U : 3'd0)
              + ACC_W'(quarter_e ? QUARTER_U : 3'd0);
    add_total = ACC_W'(credit) + coin_sum;
  end

`ifdef VM_STOCK_EN
  localparam int STK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
  logic [STK_W-1:0] stock    [N_PROD];
  logic [STK_W-1:0] stock_nx [N_PROD];
`endif

  // Out-of-range indices never hit, so they fall through to a deny
  always_comb begin
    sel_hit   = 1'b0;
    price_sel = '0;
    stocked   = 1'b1;
    for (int i = 0; i < N_PROD; i++) begin
      if (32'(sel_id) == i) begin
        sel_hit   = 1'b1;
        price_sel = PRICE_LIST[i*PRICE_W +: PRICE_W];
`ifdef VM_STOCK_EN
        stocked   = (stock[i] != '0);
`endif
      end
    end
    afford       = {{PRICE_W{1'b0}}, credit} >= {{CREDIT_W{1'b0}}, price_sel};
    vend_ok      = sel_hit & afford & stocked;
    credit_after = CREDIT_W'({{PRICE_W{1'b0}}, credit} - {{CREDIT_W{1'b0}}, price_sel});
    credit_paid  = credit - CREDIT_W'(greedy_unit(16'(credit)));
  end

  // IDLE resolves cancel, then selection, then coins; busy states reject every coin edge
  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    s_nx      = 1'b0;
    deny_nx   = 1'b0;
    rej_nx    = 1'b0;
    cancel_go = 1'b0;
    vend_fire = 1'b0;
    disp_load = 1'b0;
    case (state)
      IDLE: begin
        if (cancel && (credit != '0)) begin
          cancel_go = 1'b1;
          disp_load = 1'b1;
          rej_nx    = coin_any;
          state_nx  = PAYOUT;
          credit_nx = credit_paid;
        end else if (sel_valid) begin
          rej_nx = coin_any;
          if (vend_ok) begin
            vend_fire = 1'b1;
            s_nx      = 1'b1;
            state_nx  = VEND;
            credit_nx = credit_after;
          end else begin
            deny_nx = 1'b1;
          end
        end else if (coin_any) begin
          if (add_total <= ACC_W'(MAX_CREDIT)) credit_nx = CREDIT_W'(add_total);
          else                                 rej_nx    = 1'b1;
        end
      end
      VEND: begin
        rej_nx = coin_any;
        if (credit != '0) begin
          disp_load = 1'b1;
          state_nx  = PAYOUT;
          credit_nx = credit_paid;
        end else begin
          state_nx = IDLE;
        end
      end
      PAYOUT: begin
        rej_nx    = coin_any;
        credit_nx = credit_paid;
        if (chg_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state     <= IDLE;
      credit    <= '0;
      nickle_q  <= 1'b0;
      dime_q    <= 1'b0;
      quarter_q <= 1'b0;
      s         <= 1'b0;
      sel_deny  <= 1'b0;
      coin_rej  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      credit    <= credit_nx;
      nickle_q  <= nickle;
      dime_q    <= dime;
      quarter_q <= quarter;
      s         <= s_nx;
      sel_deny  <= deny_nx;
      coin_rej  <= rej_nx;
      busy      <= (state_nx != IDLE);
    end
  end

`ifdef VM_STOCK_EN
  // Restock wins over a same-cycle vend decrement
  always_comb begin
    for (int i = 0; i < N_PROD; i++) begin
      stock_nx[i] = stock[i];
      if ((state == IDLE) && restock)
        stock_nx[i] = STK_W'(STOCK_INIT);
      else if (vend_fire && (32'(sel_id) == i))
        stock_nx[i] = stock[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      sold_out <= '0;
      for (int i = 0; i < N_PROD; i++) stock[i] <= STK_W'(STOCK_INIT);
    end else begin
      for (int i = 0; i < N_PROD; i++) begin
        stock[i]    <= stock_nx[i];
        sold_out[i] <= (stock_nx[i] == '0);
      end
    end
  end
`endif

  vm_change_dispenser #(.W(CREDIT_W)) u_change (
    .clk      (clk),
    .rs       (rs),
    .load     (disp_load),
    .load_val (credit),
    .chg_coin (chg_coin),
    .chg_done (chg_done)
  );

endmodule
